// File: rtl/dp_ram_arb_pkg.sv
// Shared types for the dual-port RAM port arbiter.
// Holds the access FSM state encoding and requester count.
package dp_ram_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RDATA = 2'd2
    } state_e;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester
// that did not win last time gets the grant.
module rr_arbiter2
    import dp_ram_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/dp_ram_port_arbiter.sv
// Shares one registered-read RAM port between two requesters
// with round-robin arbitration and a one-access-at-a-time FSM.
module dp_ram_port_arbiter
    import dp_ram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          ram_we,
    output logic [ADDR_WIDTH-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0]         ram_wdata,
    input  logic [DATA_WIDTH-1:0]         ram_rdata
);

    state_e                state_q;
    state_e                state_d;
    logic                  last_q;
    logic                  last_d;
    logic                  we_q;
    logic                  we_d;
    logic                  id_q;
    logic                  id_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wdata_d;

    logic [NUM_REQ-1:0]    grant;
    logic                  hs;
    logic                  sel;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    rr_arbiter2 u_arb (
        .req        (req_valid),
        .last_grant (last_q),
        .grant      (grant)
    );

    // Grant is one-hot, so its upper bit is the winning requester id.
    assign sel       = grant[1];
    assign sel_we    = sel ? req_we[1] : req_we[0];
    assign sel_addr  = sel ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                           : req_addr[ADDR_WIDTH-1:0];
    assign sel_wdata = sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                           : req_wdata[DATA_WIDTH-1:0];
    assign hs        = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = hs ? ISSUE : IDLE;
            ISSUE:   state_d = we_q ? IDLE : RDATA;
            RDATA:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        last_d  = last_q;
        we_d    = we_q;
        id_d    = id_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (hs) begin
            last_d  = sel;
            we_d    = sel_we;
            id_d    = sel;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
        end
    end

    // last_q resets to 1 so requester 0 wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            id_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            last_q  <= last_d;
            we_q    <= we_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        req_ready = '0;
        ram_we    = 1'b0;
        rsp_valid = '0;
        rsp_rdata = '0;
        unique case (state_q)
            IDLE: begin
                if (rst_n) begin
                    req_ready = grant;
                end
            end
            ISSUE: begin
                ram_we = we_q;
            end
            RDATA: begin
                rsp_valid = id_to_onehot(id_q);
                rsp_rdata = ram_rdata;
            end
            default: begin
                req_ready = '0;
            end
        endcase
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

endmodule

// File: tb/tb_dp_ram_port_arbiter.sv
// Randomized scoreboard bench for dp_ram_port_arbiter with a
// registered-read RAM on the shared port.
module tb_dp_ram_port_arbiter;

    localparam int DW = 8;
    localparam int AW = 4;

    typedef struct {
        bit          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } op_t;

    typedef struct {
        int            cyc;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        int            cyc;
        logic [1:0]    id;
        logic [DW-1:0] d;
    } rs_t;

    typedef struct {
        int         cyc;
        logic [1:0] g;
    } gr_t;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_we;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;

    dp_ram_port_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // Port A of the dual-port RAM: registered read, write-through ignored.
    logic [DW-1:0] mem [16] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    bit rst_smp = 1'b0;
    bit armed = 1'b0;
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rst_smp <= !rst_n;
        if (!rst_n) armed <= 1'b1;
    end

    op_t opq [2][$];
    wr_t wq[$];
    rs_t rq[$];
    gr_t gq[$];

    logic [DW-1:0] mmem [16] = '{default: '0};
    int   busy = 0;
    bit   last = 1'b1;
    bit [1:0] cur_v = '0;
    bit [1:0] acc = '0;
    bit   dense = 1'b1;
    bit   done = 1'b0;
    int   timeouts = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic step(input bit en, input bit rst);
        logic [1:0] g;
        bit id;
        op_t op;
        @(posedge clk);
        #1;
        rst_n = rst;
        for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
                void'(opq[i].pop_front());
                cur_v[i] = 1'b0;
            end
        end
        acc = '0;
        g = '0;
        if (!rst) begin
            cur_v = '0;
            busy = 0;
            last = 1'b1;
            while (wq.size() > 0 && wq[$].cyc > cyc) void'(wq.pop_back());
            while (rq.size() > 0 && rq[$].cyc > cyc) void'(rq.pop_back());
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!cur_v[i] && en && opq[i].size() > 0 &&
                    (dense || $urandom_range(3) != 0))
                    cur_v[i] = 1'b1;
            end
            if (busy > 0) begin
                busy--;
            end else if (cur_v != 2'b00) begin
                id = (cur_v == 2'b11) ? !last : cur_v[1];
                g = id ? 2'b10 : 2'b01;
                acc = g;
                last = id;
                op = opq[id][0];
                if (op.we) begin
                    mmem[op.a] = op.d;
                    wq.push_back(wr_t'{cyc + 1, op.a, op.d});
                    busy = 1;
                end else begin
                    rq.push_back(rs_t'{cyc + 2, g, mmem[op.a]});
                    busy = 2;
                end
            end
        end
        req_valid = cur_v;
        for (int i = 0; i < 2; i++) begin
            if (cur_v[i]) begin
                req_we[i] = opq[i][0].we;
                req_addr[i*AW +: AW] = opq[i][0].a;
                req_wdata[i*DW +: DW] = opq[i][0].d;
            end
        end
        gq.push_back(gr_t'{cyc, g});
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((opq[0].size() > 0 || opq[1].size() > 0) && n < limit) begin
            step(1'b1, 1'b1);
            n++;
        end
        if (opq[0].size() > 0 || opq[1].size() > 0) begin
            $display("FAIL drain_timeout got %0d pending exp 0",
                     opq[0].size() + opq[1].size());
            timeouts++;
        end
        repeat (4) step(1'b0, 1'b1);
    endtask

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s cyc %0d got %0h exp %0h", nm, cyc, act, exp);
        end
    endtask

    initial begin : monitor
        wr_t w;
        rs_t r;
        gr_t gg;
        forever begin
            @(negedge clk);
            if (done) break;
            if (!armed) continue;
            if (rst_smp)
                chk({ram_we, ram_addr, ram_wdata, rsp_valid, rsp_rdata} == '0,
                    "rst_zero",
                    32'({ram_we, ram_addr, ram_wdata, rsp_valid, rsp_rdata}), 0);
            if (gq.size() > 0 && gq[0].cyc == cyc) begin
                gg = gq.pop_front();
                chk(req_ready == gg.g, "ready", 32'(req_ready), 32'(gg.g));
            end
            while (wq.size() > 0 && wq[0].cyc < cyc) begin
                w = wq.pop_front();
                chk(1'b0, "write_missed", 0, 32'(w.a));
            end
            if (ram_we) begin
                if (wq.size() > 0 && wq[0].cyc == cyc) begin
                    w = wq.pop_front();
                    chk(ram_addr == w.a, "wr_addr", 32'(ram_addr), 32'(w.a));
                    chk(ram_wdata == w.d, "wr_data", 32'(ram_wdata), 32'(w.d));
                end else begin
                    chk(1'b0, "unexp_we", 1, 0);
                end
            end else if (wq.size() > 0 && wq[0].cyc == cyc) begin
                w = wq.pop_front();
                chk(1'b0, "we_missing", 0, 1);
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                r = rq.pop_front();
                chk(1'b0, "rsp_missed", 0, 32'(r.id));
            end
            if (rsp_valid != 2'b00) begin
                if (rq.size() > 0 && rq[0].cyc == cyc) begin
                    r = rq.pop_front();
                    chk(rsp_valid == r.id, "rsp_id", 32'(rsp_valid), 32'(r.id));
                    chk(rsp_rdata == r.d, "rsp_data", 32'(rsp_rdata), 32'(r.d));
                end else begin
                    chk(1'b0, "unexp_rsp", 32'(rsp_valid), 0);
                end
            end else begin
                chk(rsp_rdata == '0, "rdata_idle", 32'(rsp_rdata), 0);
                if (rq.size() > 0 && rq[0].cyc == cyc) begin
                    r = rq.pop_front();
                    chk(1'b0, "rsp_missing", 0, 32'(r.id));
                end
            end
        end
        chk(wq.size() == 0, "wq_left", 32'(wq.size()), 0);
        chk(rq.size() == 0, "rq_left", 32'(rq.size()), 0);
        errors += timeouts;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stim
        int n;
        rst_n = 1'b0;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        repeat (3) step(1'b0, 1'b0);
        step(1'b0, 1'b1);

        opq[0].push_back(op_t'{1'b1, 4'h1, 8'hAB});
        drain(50);
        opq[1].push_back(op_t'{1'b0, 4'h1, 8'h00});
        drain(50);

        for (int k = 0; k < 2; k++) begin
            opq[0].push_back(op_t'{1'b1, 4'h2, 8'hCD});
            opq[1].push_back(op_t'{1'b1, 4'h3, 8'hEF});
        end
        opq[0].push_back(op_t'{1'b0, 4'h2, 8'h00});
        opq[1].push_back(op_t'{1'b0, 4'h3, 8'h00});
        drain(100);

        for (int k = 0; k < 4; k++)
            opq[1].push_back(op_t'{k[0], AW'(k + 5), DW'(8'h10 + k)});
        drain(100);

        opq[0].push_back(op_t'{1'b1, 4'hF, 8'h56});
        opq[0].push_back(op_t'{1'b0, 4'hF, 8'h00});
        drain(50);

        opq[1].push_back(op_t'{1'b0, 4'h3, 8'h00});
        n = 0;
        while (acc[1] == 1'b0 && n < 20) begin
            step(1'b1, 1'b1);
            n++;
        end
        if (acc[1] == 1'b0) begin
            $display("FAIL rst_read_accept got 0 exp 1");
            timeouts++;
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b1);

        dense = 1'b0;
        for (int k = 0; k < 300; k++) begin
            n = int'($urandom_range(1));
            opq[n].push_back(op_t'{1'($urandom_range(1)),
                                   AW'($urandom), DW'($urandom)});
        end
        drain(5000);

        repeat (3) @(posedge clk);
        done = 1'b1;
    end

endmodule
